// File: rtl/eth_pcs_cfg_pkg.sv
// Shared constants for the 10G PCS/PMA configuration_vector generator:
// vector width, bit positions and the link supervisor state encoding.
package eth_pcs_cfg_pkg;

  localparam int CV_W       = 536;
  localparam int CV_PMA_LB  = 0;
  localparam int CV_PMA_RST = 15;
  localparam int CV_TX_DIS  = 16;
  localparam int CV_PCS_LB  = 110;
  localparam int CV_PCS_RST = 111;
  localparam int CV_PRBS_TX = 244;
  localparam int CV_PRBS_RX = 245;
  localparam int CV_MDIO_LO = 384;
  localparam int CV_CLR_ST2 = 518;
  localparam int CV_CLR_ERR = 519;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    WAIT  = 2'd1,
    UP    = 2'd2,
    FAULT = 2'd3
  } link_state_t;

endpackage

// File: rtl/eth_link_supervisor.sv
// One channel: registered control levels, self-clearing clear pulses and the
// reset / wait-for-lock / up / fault supervisor.
module eth_link_supervisor
  import eth_pcs_cfg_pkg::*;
#(
  parameter int          RST_CYC      = 16,
  parameter int          LOCK_STABLE  = 1024,
  parameter int          LOCK_TIMEOUT = 2000000,
  parameter int          MAX_RETRY    = 7,
  parameter int          RETRY_W      = 4,
  parameter logic [15:0] MDIO_TICK    = 16'h4C4B
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_pma_loopback,
  input  logic               i_pcs_loopback,
  input  logic               i_tx_disable,
  input  logic               i_prbs31_en,
  input  logic               i_clr_err_req,
  input  logic               i_restart,
  input  logic               i_block_lock,
  output logic [CV_W-1:0]    o_cfg_vec,
  output logic               o_link_up,
  output logic               o_fault,
  output logic [RETRY_W-1:0] o_retry_cnt
);

  localparam int RC_W = $clog2(RST_CYC + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int SB_W = $clog2(LOCK_STABLE + 1);

  link_state_t        r_state;
  logic [RC_W-1:0]    r_rst_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [SB_W-1:0]    r_stb_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic               r_rst_bit, r_link, r_fault, r_clr_st2, r_clr_err;
  logic               r_pma_lb, r_pcs_lb, r_tx_dis, r_prbs;

  logic [TO_W-1:0]    w_to_nxt;
  logic [SB_W-1:0]    w_stb_nxt;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               w_lock_ok, w_timeout;

  assign w_to_nxt    = r_to_cnt + 1'b1;
  assign w_stb_nxt   = i_block_lock ? r_stb_cnt + 1'b1 : '0;
  assign w_lock_ok   = (w_stb_nxt == SB_W'(LOCK_STABLE));
  assign w_timeout   = (w_to_nxt == TO_W'(LOCK_TIMEOUT));
  assign w_retry_inc = (r_retry == RETRY_W'(MAX_RETRY)) ? r_retry : r_retry + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= RST;
      r_rst_cnt <= '0;
      r_to_cnt  <= '0;
      r_stb_cnt <= '0;
      r_retry   <= '0;
      r_rst_bit <= 1'b1;
      r_link    <= 1'b0;
      r_fault   <= 1'b0;
      r_clr_st2 <= 1'b0;
      r_clr_err <= 1'b0;
      r_pma_lb  <= 1'b0;
      r_pcs_lb  <= 1'b0;
      r_tx_dis  <= 1'b0;
      r_prbs    <= 1'b0;
    end else begin
      r_pma_lb  <= i_pma_loopback;
      r_pcs_lb  <= i_pcs_loopback;
      r_tx_dis  <= i_tx_disable;
      r_prbs    <= i_prbs31_en;
      r_clr_err <= i_clr_err_req;
      r_clr_st2 <= 1'b0;
      if (i_restart) begin
        r_state   <= RST;
        r_rst_cnt <= '0;
        r_to_cnt  <= '0;
        r_stb_cnt <= '0;
        r_retry   <= '0;
        r_rst_bit <= 1'b1;
        r_link    <= 1'b0;
        r_fault   <= 1'b0;
      end else begin
        case (r_state)
          RST: begin
            if (r_rst_cnt == RC_W'(RST_CYC - 1)) begin
              r_state   <= WAIT;
              r_rst_cnt <= '0;
              r_to_cnt  <= '0;
              r_stb_cnt <= '0;
              r_rst_bit <= 1'b0;
            end else begin
              r_rst_cnt <= r_rst_cnt + 1'b1;
            end
          end
          WAIT: begin
            r_to_cnt  <= w_to_nxt;
            r_stb_cnt <= w_stb_nxt;
            // A lock that completes on the timeout cycle still counts as success.
            if (w_lock_ok) begin
              r_state <= UP;
              r_link  <= 1'b1;
            end else if (w_timeout) begin
              r_retry   <= w_retry_inc;
              r_to_cnt  <= '0;
              r_stb_cnt <= '0;
              if (w_retry_inc == RETRY_W'(MAX_RETRY)) begin
                r_state <= FAULT;
                r_fault <= 1'b1;
              end else begin
                r_state   <= RST;
                r_rst_cnt <= '0;
                r_rst_bit <= 1'b1;
              end
            end
          end
          UP: begin
            if (!i_block_lock) begin
              r_state   <= WAIT;
              r_link    <= 1'b0;
              r_to_cnt  <= '0;
              r_stb_cnt <= '0;
              r_clr_st2 <= 1'b1;
            end
          end
          FAULT: ;
          default: begin
            r_state   <= RST;
            r_rst_cnt <= '0;
            r_rst_bit <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    o_cfg_vec                      = '0;
    o_cfg_vec[CV_PMA_LB]           = r_pma_lb;
    o_cfg_vec[CV_PMA_RST]          = r_rst_bit;
    o_cfg_vec[CV_TX_DIS]           = r_tx_dis;
    o_cfg_vec[CV_PCS_LB]           = r_pcs_lb;
    o_cfg_vec[CV_PCS_RST]          = r_rst_bit;
    o_cfg_vec[CV_PRBS_TX]          = r_prbs;
    o_cfg_vec[CV_PRBS_RX]          = r_prbs;
    o_cfg_vec[CV_MDIO_LO +: 16]    = MDIO_TICK;
    o_cfg_vec[CV_CLR_ST2]          = r_clr_st2;
    o_cfg_vec[CV_CLR_ERR]          = r_clr_err;
  end

  assign o_link_up   = r_link;
  assign o_fault     = r_fault;
  assign o_retry_cnt = r_retry;

endmodule

// File: rtl/eth_pcs_cfg_ctrl.sv
// Multi-channel configuration_vector generator: one supervisor per channel,
// outputs packed channel-major into the flat buses.
module eth_pcs_cfg_ctrl
  import eth_pcs_cfg_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          RST_CYC      = 16,
  parameter int          LOCK_STABLE  = 1024,
  parameter int          LOCK_TIMEOUT = 2000000,
  parameter int          MAX_RETRY    = 7,
  parameter int          RETRY_W      = 4,
  parameter logic [15:0] MDIO_TICK    = 16'h4C4B
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_CH-1:0]         pma_loopback,
  input  logic [NUM_CH-1:0]         pcs_loopback,
  input  logic [NUM_CH-1:0]         tx_disable,
  input  logic [NUM_CH-1:0]         prbs31_en,
  input  logic [NUM_CH-1:0]         clr_err_req,
  input  logic [NUM_CH-1:0]         restart,
  input  logic [NUM_CH-1:0]         block_lock,
  output logic [NUM_CH*CV_W-1:0]    configuration_vector,
  output logic [NUM_CH-1:0]         link_up,
  output logic [NUM_CH-1:0]         fault,
  output logic [NUM_CH*RETRY_W-1:0] retry_cnt
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      eth_link_supervisor #(
        .RST_CYC      (RST_CYC),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY),
        .RETRY_W      (RETRY_W),
        .MDIO_TICK    (MDIO_TICK)
      ) u_sup (
        .clk            (clk),
        .resetn         (resetn),
        .i_pma_loopback (pma_loopback[gi]),
        .i_pcs_loopback (pcs_loopback[gi]),
        .i_tx_disable   (tx_disable[gi]),
        .i_prbs31_en    (prbs31_en[gi]),
        .i_clr_err_req  (clr_err_req[gi]),
        .i_restart      (restart[gi]),
        .i_block_lock   (block_lock[gi]),
        .o_cfg_vec      (configuration_vector[gi*CV_W +: CV_W]),
        .o_link_up      (link_up[gi]),
        .o_fault        (fault[gi]),
        .o_retry_cnt    (retry_cnt[gi*RETRY_W +: RETRY_W])
      );
    end
  endgenerate

endmodule
